id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register that directly feeds the ALU. It accepts one decoded instruction per cycle through a valid/ready handshake and holds it for the execute stage. It resolves the two ALU operands using operand-select and MEM/WB forwarding, and drives `alu_src1`, `alu_src2` and `alu_func` into the ALU. It also detects load-use hazards and supports stall and flush from the pipeline control.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register index width

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage accepts on this edge
- `in_pc`, `in_rs1_data`, `in_rs2_data`, `in_imm`  in  XLEN each  decoded operands
- `in_rs1`, `in_rs2`, `in_rd`  in  REG_AW each  register indices
- `in_alu_func`  in  4  ALU opcode, passed through unchanged
- `in_src1_sel`  in  1  0 = rs1, 1 = pc
- `in_src2_sel`  in  1  0 = rs2, 1 = imm
- `in_reg_we`, `in_mem_rd`  in  1 each  writes rd / is load
- `flush`  in  1  kill instruction held in EX
- `ex_stall`  in  1  downstream cannot advance
- `mem_rd`  in  REG_AW; `mem_reg_we`, `mem_is_load`  in  1 each; `mem_result`  in  XLEN  — MEM-stage forward source
- `wb_rd`  in  REG_AW; `wb_reg_we`  in  1; `wb_result`  in  XLEN  — WB-stage forward source
- `alu_src1`, `alu_src2`  out  XLEN each  ALU operands
- `alu_func`  out  4  ALU opcode
- `out_valid`, `out_reg_we`, `out_mem_rd`  out  1 each
- `out_rd`  out  REG_AW
- `out_store_data`  out  XLEN  forwarded rs2 value
- `hazard_stall`  out  1  load-use/RAW stall request to fetch/decode

## Operation
- The register holds every `in_*` field plus a valid bit.
- Update priority on each edge:
  - flush: valid←0, other fields don't-care.
  - else ex_stall: hold all fields.
  - else hazard_stall: valid←0 (bubble).
  - else: load `in_*`, valid←`in_valid`.
- `in_ready` = !ex_stall & !hazard_stall & !flush.
- Load-use hazard: `hazard_stall` = in_valid & out_valid & out_mem_rd & out_reg_we & out_rd≠0 & (in_rs1==out_rd | in_rs2==out_rd). The check is conservative and fires even when the instruction uses an immediate.
- Forwarding, combinational from the held fields, per source operand (rs1, rs2):
  - Index 0 is never forwarded; the value is the held register data.
  - MEM match: mem_reg_we & mem_rd==idx & !mem_is_load → `mem_result`.
  - Else WB match: wb_reg_we & wb_rd==idx → `wb_result`.
  - Else the held `*_data`.
  - MEM has priority over WB.
- Operand selection:
  - `alu_src1` = src1_sel ? held pc : forwarded rs1.
  - `alu_src2` = src2_sel ? held imm : forwarded rs2.
  - `out_store_data` = forwarded rs2 regardless of src2_sel.
- `alu_func` and `out_*` are the held fields. With `out_valid`=0 the downstream ignores them.

## Timing
- Reset (async): every held field is 0, so `out_valid`=0, `alu_func`=0, `alu_src1`=`alu_src2`=0, `out_rd`=0, and `out_reg_we`=`out_mem_rd`=0.
- Latency: an instruction accepted at edge N presents ALU operands in the cycle after N. Throughput is 1 per cycle.
- Forward muxes are same-cycle combinational. The ALU result is expected in that cycle.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in WB and is forwarded from `wb_result`.
- flush and ex_stall together: flush wins and valid drops.
- flush together with a hazard: `in_ready`=0, so decode must re-present after the flush.
- Reset mid-stall: all state clears immediately and `hazard_stall` drops because `out_valid`=0.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding as above, and `hazard_stall` covers load-use only.
- Undefined: no forward muxes, so operands come straight from the held `*_data`. `hazard_stall` then fires for any nonzero in_rs1/in_rs2 matching:
  - out_rd with out_valid & out_reg_we, or
  - mem_rd with mem_reg_we, or
  - wb_rd with wb_reg_we.
  Stalls repeat until no match remains.

## Test plan
- Reset asserted mid-stream → next sample: out_valid=0, alu_src1=alu_src2=0, alu_func=0, hazard_stall=0.
- Held rs1=3 (data 5), mem_rd=3, mem_reg_we=1, mem_result=0x10, and wb_rd=3 with wb_result=0x20 → alu_src1=0x10 (MEM priority). With mem_reg_we=0 → 0x20.
- Held rs2=0, wb_rd=0, wb_reg_we=1, wb_result=0xFF → alu_src2 = held rs2_data (x0 never forwarded).
- Load to x5 held in EX; in_rs1=5 presented → hazard_stall=1, in_ready=0, bubble next cycle. On re-accept with wb_rd=5 and wb_result=0x1234 → alu_src1=0x1234.
- ex_stall=1 for 3 cycles with instruction held → alu_func and out_rd unchanged, in_ready=0. flush during the stall → out_valid=0 on the next edge.
- src2_sel=1, imm=0xFFFFFFFC, rs2 forwarded 7 → alu_src2=0xFFFFFFFC, out_store_data=7.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register feeding the ALU. Holds one decoded
// instruction, resolves the two ALU operands (operand select plus optional
// MEM/WB forwarding) and raises hazard_stall towards fetch/decode.
//
// Configuration macro: ID_EX_FORWARD_EN
//   defined   : MEM/WB forwarding muxes; hazard_stall covers load-use only.
//   undefined : operands come straight from the held register data;
//               hazard_stall fires on any RAW match against EX, MEM or WB.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   in_valid / in_ready          decode handshake
//   in_pc, in_rs1_data,
//   in_rs2_data, in_imm          decoded operand values
//   in_rs1, in_rs2, in_rd        register indices
//   in_alu_func                  ALU opcode (passed through)
//   in_src1_sel, in_src2_sel     0 = register, 1 = pc / imm
//   in_reg_we, in_mem_rd         writes rd / is a load
//   flush, ex_stall              pipeline control
//   mem_rd, mem_reg_we,
//   mem_is_load, mem_result      MEM-stage forward source
//   wb_rd, wb_reg_we, wb_result  WB-stage forward source
//   alu_src1, alu_src2, alu_func ALU drive
//   out_valid, out_reg_we,
//   out_mem_rd, out_rd,
//   out_store_data               held fields / forwarded rs2 for stores
//   hazard_stall                 stall request to fetch/decode
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [3:0]        in_alu_func,
  input  logic              in_src1_sel,
  input  logic              in_src2_sel,
  input  logic              in_reg_we,
  input  logic              in_mem_rd,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_we,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_we,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   alu_src1,
  output logic [XLEN-1:0]   alu_src2,
  output logic [3:0]        alu_func,
  output logic              out_valid,
  output logic              out_reg_we,
  output logic              out_mem_rd,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_store_data,
  output logic              hazard_stall
);

  // Held instruction fields
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [3:0]        ex_func;
  logic              ex_src1_sel;
  logic              ex_src2_sel;
  logic              ex_reg_we;
  logic              ex_mem_rd;

  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  // True when a nonzero source index matches a writing destination.
  function automatic logic rd_match(input logic [REG_AW-1:0] src,
                                    input logic [REG_AW-1:0] dst,
                                    input logic              we);
    return we && (src != {REG_AW{1'b0}}) && (src == dst);
  endfunction

`ifdef ID_EX_FORWARD_EN
  // Load-use: the load in EX has no data until WB, so one bubble is needed.
  always_comb begin
    hazard_stall = in_valid && ex_valid && ex_mem_rd &&
                   (rd_match(in_rs1, ex_rd, ex_reg_we) ||
                    rd_match(in_rs2, ex_rd, ex_reg_we));
  end

  // Forward muxes; MEM wins over WB, a load still in MEM has no result yet.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    fwd_rs2 = ex_rs2_data;
    if (rd_match(ex_rs1, mem_rd, mem_reg_we) && !mem_is_load) begin
      fwd_rs1 = mem_result;
    end else if (rd_match(ex_rs1, wb_rd, wb_reg_we)) begin
      fwd_rs1 = wb_result;
    end else begin
      fwd_rs1 = ex_rs1_data;
    end
    if (rd_match(ex_rs2, mem_rd, mem_reg_we) && !mem_is_load) begin
      fwd_rs2 = mem_result;
    end else if (rd_match(ex_rs2, wb_rd, wb_reg_we)) begin
      fwd_rs2 = wb_result;
    end else begin
      fwd_rs2 = ex_rs2_data;
    end
  end
`else
  // No bypass network: stall while any in-flight writer matches a source.
  always_comb begin
    hazard_stall = in_valid &&
                   (rd_match(in_rs1, ex_rd, ex_valid && ex_reg_we) ||
                    rd_match(in_rs2, ex_rd, ex_valid && ex_reg_we) ||
                    rd_match(in_rs1, mem_rd, mem_reg_we) ||
                    rd_match(in_rs2, mem_rd, mem_reg_we) ||
                    rd_match(in_rs1, wb_rd, wb_reg_we) ||
                    rd_match(in_rs2, wb_rd, wb_reg_we));
  end

  // Operands come directly from the held register data.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    fwd_rs2 = ex_rs2_data;
  end

  // Forward-only inputs and held indices have no consumer in this build.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_result, wb_result, mem_is_load, ex_rs1, ex_rs2};
`endif

  // Handshake: decode may only advance when this stage will load.
  always_comb begin
    in_ready = !ex_stall && !hazard_stall && !flush;
  end

  // Pipeline register: flush > ex_stall > hazard bubble > load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= {XLEN{1'b0}};
      ex_rs1_data <= {XLEN{1'b0}};
      ex_rs2_data <= {XLEN{1'b0}};
      ex_imm      <= {XLEN{1'b0}};
      ex_rs1      <= {REG_AW{1'b0}};
      ex_rs2      <= {REG_AW{1'b0}};
      ex_rd       <= {REG_AW{1'b0}};
      ex_func     <= 4'h0;
      ex_src1_sel <= 1'b0;
      ex_src2_sel <= 1'b0;
      ex_reg_we   <= 1'b0;
      ex_mem_rd   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_stall) begin
      ex_valid <= ex_valid;
    end else if (hazard_stall) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid    <= in_valid;
      ex_pc       <= in_pc;
      ex_rs1_data <= in_rs1_data;
      ex_rs2_data <= in_rs2_data;
      ex_imm      <= in_imm;
      ex_rs1      <= in_rs1;
      ex_rs2      <= in_rs2;
      ex_rd       <= in_rd;
      ex_func     <= in_alu_func;
      ex_src1_sel <= in_src1_sel;
      ex_src2_sel <= in_src2_sel;
      ex_reg_we   <= in_reg_we;
      ex_mem_rd   <= in_mem_rd;
    end
  end

  // Operand select; store data is always the (forwarded) rs2 value.
  always_comb begin
    alu_src1       = ex_src1_sel ? ex_pc  : fwd_rs1;
    alu_src2       = ex_src2_sel ? ex_imm : fwd_rs2;
    out_store_data = fwd_rs2;
  end

  assign alu_func   = ex_func;
  assign out_valid  = ex_valid;
  assign out_reg_we = ex_reg_we;
  assign out_mem_rd = ex_mem_rd;
  assign out_rd     = ex_rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed vectors for id_ex_stage. The stimulus process pushes the expected
// outputs of every cycle into a queue; a monitor pops one entry per falling
// edge and compares. Expectations follow the ID_EX_FORWARD_EN build setting.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_alu_func;
  logic        in_src1_sel, in_src2_sel, in_reg_we, in_mem_rd;
  logic        flush, ex_stall;
  logic [4:0]  mem_rd;
  logic        mem_reg_we, mem_is_load;
  logic [31:0] mem_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_we;
  logic [31:0] wb_result;
  logic [31:0] alu_src1, alu_src2, out_store_data;
  logic [3:0]  alu_func;
  logic        out_valid, out_reg_we, out_mem_rd, hazard_stall;
  logic [4:0]  out_rd;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_alu_func(in_alu_func), .in_src1_sel(in_src1_sel),
    .in_src2_sel(in_src2_sel), .in_reg_we(in_reg_we), .in_mem_rd(in_mem_rd),
    .flush(flush), .ex_stall(ex_stall), .mem_rd(mem_rd),
    .mem_reg_we(mem_reg_we), .mem_is_load(mem_is_load),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
    .wb_result(wb_result), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_func(alu_func), .out_valid(out_valid), .out_reg_we(out_reg_we),
    .out_mem_rd(out_mem_rd), .out_rd(out_rd),
    .out_store_data(out_store_data), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic        v, hz, rdy;
    logic [31:0] s1, s2, sd;
    logic [3:0]  f;
    logic [4:0]  rd;
    logic        we, mrd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   step_no  = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, req);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      step_no++;
      cmp("out_valid",    {31'd0, out_valid},    {31'd0, e.v});
      cmp("hazard_stall", {31'd0, hazard_stall}, {31'd0, e.hz});
      cmp("in_ready",     {31'd0, in_ready},     {31'd0, e.rdy});
      if (e.chk) begin
        cmp("alu_src1",       alu_src1,             e.s1);
        cmp("alu_src2",       alu_src2,             e.s2);
        cmp("out_store_data", out_store_data,       e.sd);
        cmp("alu_func",       {28'd0, alu_func},    {28'd0, e.f});
        cmp("out_rd",         {27'd0, out_rd},      {27'd0, e.rd});
        cmp("out_reg_we",     {31'd0, out_reg_we},  {31'd0, e.we});
        cmp("out_mem_rd",     {31'd0, out_mem_rd},  {31'd0, e.mrd});
      end
    end
  end

  task automatic push(input bit chk, input logic v, input logic hz, input logic rdy,
                      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] sd,
                      input logic [3:0] f, input logic [4:0] rd, input logic we,
                      input logic mrd);
    exp_t e;
    e.chk = chk; e.v = v; e.hz = hz; e.rdy = rdy;
    e.s1 = s1; e.s2 = s2; e.sd = sd; e.f = f; e.rd = rd; e.we = we; e.mrd = mrd;
    exp_q.push_back(e);
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [31:0] rs1d,
                        input logic [4:0] rs2, input logic [31:0] rs2d,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [3:0] f, input logic s1sel, input logic s2sel,
                        input logic we, input logic mrd);
    in_valid = v; in_pc = pc; in_rs1 = rs1; in_rs1_data = rs1d;
    in_rs2 = rs2; in_rs2_data = rs2d; in_imm = imm; in_rd = rd;
    in_alu_func = f; in_src1_sel = s1sel; in_src2_sel = s2sel;
    in_reg_we = we; in_mem_rd = mrd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_rd = 5'd0; mem_reg_we = 1'b0; mem_is_load = 1'b0; mem_result = 32'h0;
    wb_rd = 5'd0; wb_reg_we = 1'b0; wb_result = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state while instruction A is presented
    set_in(1'b1, 32'h100, 5'd1, 32'h11, 5'd2, 32'h22, 32'h4, 5'd7, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0); tick();
    // A held under ex_stall
    in_valid = 1'b0; ex_stall = 1'b1;
    push(1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22, 32'h22, 4'h3, 5'd7, 1'b1, 1'b0); tick();
    // Reset asserted mid-stall clears everything at once
    rst = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0); tick();
    rst = 1'b0; ex_stall = 1'b0;

    // Present B: rs1=x3 (data 5), rs2=x0 (data 0x99)
    set_in(1'b1, 32'h200, 5'd3, 32'h5, 5'd0, 32'h99, 32'h8, 5'd9, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0); tick();
    // B held 3+ cycles; MEM and WB both write x3
    ex_stall = 1'b1;
    mem_rd = 5'd3; mem_reg_we = 1'b1; mem_is_load = 1'b0; mem_result = 32'h10;
    wb_rd = 5'd3; wb_reg_we = 1'b1; wb_result = 32'h20;
`ifdef ID_EX_FORWARD_EN
    push(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h99, 32'h99, 4'h5, 5'd9, 1'b1, 1'b0); tick();
`else
    push(1'b1, 1'b1, 1'b1, 1'b0, 32'h5,  32'h99, 32'h99, 4'h5, 5'd9, 1'b1, 1'b0); tick();
`endif
    mem_reg_we = 1'b0;
`ifdef ID_EX_FORWARD_EN
    push(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h99, 32'h99, 4'h5, 5'd9, 1'b1, 1'b0); tick();
`else
    push(1'b1, 1'b1, 1'b1, 1'b0, 32'h5,  32'h99, 32'h99, 4'h5, 5'd9, 1'b1, 1'b0); tick();
`endif
    // A load still in MEM is not a forward source
    mem_reg_we = 1'b1; mem_is_load = 1'b1;
`ifdef ID_EX_FORWARD_EN
    push(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h99, 32'h99, 4'h5, 5'd9, 1'b1, 1'b0); tick();
`else
    push(1'b1, 1'b1, 1'b1, 1'b0, 32'h5,  32'h99, 32'h99, 4'h5, 5'd9, 1'b1, 1'b0); tick();
`endif
    // x0 is never forwarded and never causes a hazard
    mem_reg_we = 1'b0; mem_is_load = 1'b0;
    wb_rd = 5'd0; wb_reg_we = 1'b1; wb_result = 32'hFF;
    in_rs1 = 5'd0; in_rs2 = 5'd0;
    push(1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 32'h99, 32'h99, 4'h5, 5'd9, 1'b1, 1'b0); tick();
    // flush during ex_stall: flush wins
    in_valid = 1'b0; wb_reg_we = 1'b0; flush = 1'b1;
    push(1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 32'h99, 32'h99, 4'h5, 5'd9, 1'b1, 1'b0); tick();
    flush = 1'b0; ex_stall = 1'b0;

    // Present C: src1=pc, src2=imm 0xFFFFFFFC, rs2=x6
    set_in(1'b1, 32'h300, 5'd4, 32'h40, 5'd6, 32'h60, 32'hFFFF_FFFC, 5'd10, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0); tick();
    // C held, MEM forwards 7 to rs2; present load D (x5 <- mem[x1+0x10])
    mem_rd = 5'd6; mem_reg_we = 1'b1; mem_result = 32'h7;
    set_in(1'b1, 32'h400, 5'd1, 32'h1, 5'd0, 32'h0, 32'h10, 5'd5, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef ID_EX_FORWARD_EN
    push(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'hFFFF_FFFC, 32'h7,  4'h2, 5'd10, 1'b1, 1'b0); tick();
`else
    push(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'hFFFF_FFFC, 32'h60, 4'h2, 5'd10, 1'b1, 1'b0); tick();
`endif
    // D held in EX; E reads x5 -> load-use hazard
    mem_reg_we = 1'b0;
    set_in(1'b1, 32'h500, 5'd5, 32'hBAD, 5'd2, 32'h22, 32'h0, 5'd11, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 32'h10, 32'h0, 4'h0, 5'd5, 1'b1, 1'b1); tick();
    // Bubble; load now in MEM
    mem_rd = 5'd5; mem_reg_we = 1'b1; mem_is_load = 1'b1; mem_result = 32'hDEAD;
`ifdef ID_EX_FORWARD_EN
    push(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0); tick();
    // E in EX, load in WB forwards 0x1234
    in_valid = 1'b0; mem_reg_we = 1'b0; mem_is_load = 1'b0;
    wb_rd = 5'd5; wb_reg_we = 1'b1; wb_result = 32'h1234;
    push(1'b1, 1'b1, 1'b0, 1'b1, 32'h1234, 32'h22, 32'h22, 4'h1, 5'd11, 1'b1, 1'b0); tick();
`else
    push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0); tick();
    // Writer moves to WB: still stalled
    mem_reg_we = 1'b0; mem_is_load = 1'b0;
    wb_rd = 5'd5; wb_reg_we = 1'b1; wb_result = 32'h1234;
    push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0); tick();
    // No writer left: E accepted
    wb_reg_we = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    push(1'b1, 1'b1, 1'b0, 1'b1, 32'hBAD, 32'h22, 32'h22, 4'h1, 5'd11, 1'b1, 1'b0); tick();
`endif
    // Idle: valid drops after the last instruction leaves
    wb_reg_we = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0); tick();

    // Bounded drain of the expectation queue
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
